// File: rtl/cr_prefix_fe_ctlr_pkg.sv
// Shared types and constants for the prefix-engine feature-extraction controller.
package cr_prefix_fe_ctlr_pkg;

    localparam int unsigned FE_MAX_BYTES = 4096;
    localparam int unsigned FE_WIN_BYTES = 1024;
    localparam int unsigned FE_NUM_WIN   = 4;

    typedef enum logic [1:0] {
        STREAM,
        EODB,
        DRAIN,
        REPORT
    } fe_ctlr_state_e;

    typedef struct packed {
        logic [12:0] nbytes;
        logic [2:0]  nwin;
        logic        trunc;
        logic        err;
    } fe_ctlr_rpt_t;

endpackage

// File: rtl/cr_prefix_fe_ctlr_mask.sv
// Combinational per-word mask logic: effective (truncated) mask, its popcount,
// truncation hit and partial-mask detection.
module cr_prefix_fe_ctlr_mask
    import cr_prefix_fe_ctlr_pkg::*;
#(
    parameter int unsigned MAX_BYTES = FE_MAX_BYTES
) (
    input  logic [7:0]  in_vbytes,
    input  logic [12:0] byte_cnt,
    output logic [7:0]  eff_vbytes,
    output logic [3:0]  eff_cnt,
    output logic        trunc_hit,
    output logic        partial
);

    logic [13:0] room;

    // Bytes are kept in lane order until the remaining room is used up.
    always_comb begin
        eff_vbytes = '0;
        eff_cnt    = '0;
        trunc_hit  = 1'b0;
        room       = 14'(MAX_BYTES) - {1'b0, byte_cnt};
        for (int unsigned i = 0; i < 8; i++) begin
            if (in_vbytes[i]) begin
                if ({10'b0, eff_cnt} < room) begin
                    eff_vbytes[i] = 1'b1;
                    eff_cnt       = eff_cnt + 4'd1;
                end else begin
                    trunc_hit = 1'b1;
                end
            end
        end
    end

    assign partial = (in_vbytes != '1);

endmodule

// File: rtl/cr_prefix_fe_ctlr.sv
// Feature-extraction counter group sequencer: streams words, pulses EODB, drains,
// then reports block length. Optional stats ports under CR_PREFIX_FE_CTLR_STATS_EN.
module cr_prefix_fe_ctlr
    import cr_prefix_fe_ctlr_pkg::*;
#(
    parameter int unsigned MAX_BYTES = FE_MAX_BYTES,
    parameter int unsigned WIN_BYTES = FE_WIN_BYTES,
    parameter int unsigned DRAIN_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [7:0]  in_vbytes,
    input  logic        in_eob,
    output logic [63:0] fe_char_in,
    output logic [7:0]  fe_char_vbytes,
    output logic [1:0]  fe_sel_1k,
    output logic        fe_ctlr_eodb,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [12:0] out_nbytes,
    output logic [2:0]  out_nwin,
    output logic        out_trunc,
    output logic        out_err
`ifdef CR_PREFIX_FE_CTLR_STATS_EN
    ,
    output logic [31:0] stat_blocks,
    output logic [15:0] stat_trunc
`endif
);

    fe_ctlr_state_e state, state_nxt;

    logic [12:0]  byte_cnt;
    logic         trunc_q;
    logic         err_q;
    logic [2:0]   drain_cnt;
    logic         accept;
    logic [7:0]   eff_vbytes;
    logic [3:0]   eff_cnt;
    logic         trunc_hit;
    logic         partial;
    logic [12:0]  win_idx;
    logic [1:0]   sel_now;
    logic [13:0]  nwin_full;
    fe_ctlr_rpt_t rpt;

    cr_prefix_fe_ctlr_mask #(
        .MAX_BYTES(MAX_BYTES)
    ) u_mask (
        .in_vbytes  (in_vbytes),
        .byte_cnt   (byte_cnt),
        .eff_vbytes (eff_vbytes),
        .eff_cnt    (eff_cnt),
        .trunc_hit  (trunc_hit),
        .partial    (partial)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= STREAM;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            STREAM: begin
                in_ready = 1'b1;
                if (in_valid && in_eob) state_nxt = EODB;
            end
            EODB:   state_nxt = DRAIN;
            DRAIN:  if (drain_cnt == '0) state_nxt = REPORT;
            REPORT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = STREAM;
            end
            default: state_nxt = STREAM;
        endcase
    end

    assign accept  = in_valid && in_ready;
    assign win_idx = byte_cnt / 13'(WIN_BYTES);
    assign sel_now = (win_idx > 13'd3) ? 2'd3 : win_idx[1:0];

    // The group sees data one cycle after accept, so the EODB pulse is also
    // registered to land after the last word's byte mask.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fe_char_in     <= '0;
            fe_char_vbytes <= '0;
            fe_sel_1k      <= '0;
            fe_ctlr_eodb   <= 1'b0;
            byte_cnt       <= '0;
            trunc_q        <= 1'b0;
            err_q          <= 1'b0;
            drain_cnt      <= '0;
        end else begin
            fe_ctlr_eodb   <= (state == EODB);
            fe_char_vbytes <= '0;
            if (accept) begin
                fe_char_in     <= in_data;
                fe_char_vbytes <= eff_vbytes;
                fe_sel_1k      <= sel_now;
                byte_cnt       <= byte_cnt + 13'(eff_cnt);
                if (trunc_hit)           trunc_q <= 1'b1;
                if (partial && !in_eob)  err_q   <= 1'b1;
            end
            if (state == EODB)
                drain_cnt <= 3'(DRAIN_CYC - 1);
            else if (state == DRAIN && drain_cnt != '0)
                drain_cnt <= drain_cnt - 3'd1;
            if (out_valid && out_ready) begin
                byte_cnt <= '0;
                trunc_q  <= 1'b0;
                err_q    <= 1'b0;
            end
        end
    end

    assign nwin_full   = ({1'b0, byte_cnt} + 14'(WIN_BYTES - 1)) / 14'(WIN_BYTES);
    assign rpt.nbytes  = byte_cnt;
    assign rpt.nwin    = (nwin_full > 14'd4) ? 3'd4 : nwin_full[2:0];
    assign rpt.trunc   = trunc_q;
    assign rpt.err     = err_q;

    assign out_nbytes = out_valid ? rpt.nbytes : '0;
    assign out_nwin   = out_valid ? rpt.nwin   : '0;
    assign out_trunc  = out_valid && rpt.trunc;
    assign out_err    = out_valid && rpt.err;

`ifdef CR_PREFIX_FE_CTLR_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_blocks <= '0;
            stat_trunc  <= '0;
        end else if (out_valid && out_ready) begin
            stat_blocks <= stat_blocks + 32'd1;
            if (trunc_q) stat_trunc <= stat_trunc + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cr_prefix_fe_ctlr.sv
// Randomized self-checking bench for cr_prefix_fe_ctlr against a byte-level block model.
module tb_cr_prefix_fe_ctlr;

    localparam int DC = 2;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [7:0]  in_vbytes;
    logic        in_eob;
    logic [63:0] fe_char_in;
    logic [7:0]  fe_char_vbytes;
    logic [1:0]  fe_sel_1k;
    logic        fe_ctlr_eodb;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] out_nbytes;
    logic [2:0]  out_nwin;
    logic        out_trunc;
    logic        out_err;
`ifdef CR_PREFIX_FE_CTLR_STATS_EN
    logic [31:0] stat_blocks;
    logic [15:0] stat_trunc;
    int          exp_blocks;
    int          exp_strunc;
`endif

    int checks;
    int errors;
    logic [7:0] q_vb[$];

    cr_prefix_fe_ctlr #(
        .DRAIN_CYC(DC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_vbytes      (in_vbytes),
        .in_eob         (in_eob),
        .fe_char_in     (fe_char_in),
        .fe_char_vbytes (fe_char_vbytes),
        .fe_sel_1k      (fe_sel_1k),
        .fe_ctlr_eodb   (fe_ctlr_eodb),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_nbytes     (out_nbytes),
        .out_nwin       (out_nwin),
        .out_trunc      (out_trunc),
        .out_err        (out_err)
`ifdef CR_PREFIX_FE_CTLR_STATS_EN
        ,
        .stat_blocks    (stat_blocks),
        .stat_trunc     (stat_trunc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Plays q_vb as one block; rst_word >= 0 pulses reset while that word is offered.
    task automatic play_block(input int hold, input int rst_word, input int gap_pct);
        int          cnt;
        bit          trn;
        bit          er;
        int          nwin;
        int          last;
        int          lat;
        int          g;
        logic [7:0]  eff[$];
        logic [1:0]  sel[$];
        logic [63:0] d;

        cnt  = 0;
        trn  = 0;
        er   = 0;
        last = q_vb.size() - 1;
        for (int i = 0; i <= last; i++) begin
            int         s;
            logic [7:0] e;
            s = cnt / 1024;
            if (s > 3) s = 3;
            sel.push_back(2'(s));
            e = '0;
            for (int b = 0; b < 8; b++) begin
                if (q_vb[i][b]) begin
                    if (cnt < 4096) begin
                        e[b] = 1'b1;
                        cnt++;
                    end else begin
                        trn = 1;
                    end
                end
            end
            eff.push_back(e);
            if (i != last && q_vb[i] != 8'hFF) er = 1;
        end
        nwin = (cnt + 1023) / 1024;

        for (int i = 0; i <= last; i++) begin
            g = 0;
            while (g < 3 && $urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                @(negedge clk);
                chk("idle_vbytes", fe_char_vbytes, 0);
                g++;
            end
            d         = {$urandom, $urandom};
            in_valid  = 1'b1;
            in_data   = d;
            in_vbytes = q_vb[i];
            in_eob    = (i == last);
            chk("in_ready_stream", in_ready, 1);
            if (i == rst_word) rst_n = 1'b0;
            @(negedge clk);
            if (i == rst_word) begin
                rst_n    = 1'b1;
                in_valid = 1'b0;
                in_eob   = 1'b0;
                chk("rst_vbytes", fe_char_vbytes, 0);
                chk("rst_char", fe_char_in, 0);
                chk("rst_sel", fe_sel_1k, 0);
                chk("rst_in_ready", in_ready, 1);
                for (int k = 0; k < 2 * DC + 4; k++) begin
                    @(negedge clk);
                    chk("rst_no_eodb", fe_ctlr_eodb, 0);
                    chk("rst_no_report", out_valid, 0);
                end
`ifdef CR_PREFIX_FE_CTLR_STATS_EN
                exp_blocks = 0;
                exp_strunc = 0;
`endif
                return;
            end
            chk("char", fe_char_in, d);
            chk("vbytes", fe_char_vbytes, eff[i]);
            chk("sel_1k", fe_sel_1k, sel[i]);
        end
        in_valid = 1'b0;
        in_eob   = 1'b0;

        chk("in_ready_eodb", in_ready, 0);
        chk("eodb_early", fe_ctlr_eodb, 0);
        @(negedge clk);
        chk("eodb_pulse", fe_ctlr_eodb, 1);
        chk("eodb_vbytes", fe_char_vbytes, 0);
        lat = 1;
        while (!out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
            chk("eodb_single", fe_ctlr_eodb, 0);
        end
        chk("rpt_latency", lat, DC + 1);

        for (int h = 0; h <= hold; h++) begin
            chk("out_valid", out_valid, 1);
            chk("nbytes", out_nbytes, cnt);
            chk("nwin", out_nwin, nwin);
            chk("trunc", out_trunc, trn);
            chk("err", out_err, er);
            chk("in_ready_rpt", in_ready, 0);
            if (h < hold) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_clr", out_valid, 0);
        chk("in_ready_next", in_ready, 1);
`ifdef CR_PREFIX_FE_CTLR_STATS_EN
        exp_blocks++;
        if (trn) exp_strunc++;
        chk("stat_blocks", stat_blocks, exp_blocks);
        chk("stat_trunc", stat_trunc, exp_strunc);
`endif
    endtask

    task automatic fill(input int n_full, input logic [7:0] last_vb);
        q_vb.delete();
        for (int i = 0; i < n_full; i++) q_vb.push_back(8'hFF);
        q_vb.push_back(last_vb);
    endtask

    initial begin
        int len;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_vbytes = '0;
        in_eob    = 1'b0;
        out_ready = 1'b0;
`ifdef CR_PREFIX_FE_CTLR_STATS_EN
        exp_blocks = 0;
        exp_strunc = 0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_eodb", fe_ctlr_eodb, 0);
        chk("reset_vbytes", fe_char_vbytes, 0);
        chk("reset_char", fe_char_in, 0);
        chk("reset_sel", fe_sel_1k, 0);
        chk("reset_fields", {out_nbytes, out_nwin, out_trunc, out_err}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        fill(511, 8'hFF);                 play_block(0, -1, 10);
        fill(3, 8'h07);                   play_block(1, -1, 20);
        fill(512, 8'hFF);                 play_block(0, -1, 5);
        q_vb.delete();
        q_vb.push_back(8'h0F);
        q_vb.push_back(8'hFF);            play_block(2, -1, 0);
        fill(0, 8'h00);                   play_block(5, -1, 0);
        fill(19, 8'hFF);                  play_block(0, 10, 0);
        fill(1, 8'hFF);                   play_block(0, -1, 0);

        for (int b = 0; b < 10; b++) begin
            len = (b == 9) ? int'($urandom_range(505, 520)) : int'($urandom_range(1, 12));
            q_vb.delete();
            for (int i = 0; i < len; i++)
                q_vb.push_back(($urandom_range(3) == 0) ? 8'($urandom) : 8'hFF);
            play_block(int'($urandom_range(0, 3)), -1, 15);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
